// File: rtl/mem_dump_reader.sv
// mem_dump_reader: stalls the CPU, reads a contiguous RAM word range over the secondary
// read port and streams each word with its address. Define MEM_DUMP_CSUM_EN for the csum output.
module mem_dump_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_cnt,
  output logic              cpu_hold,
  input  logic              cpu_idle,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef MEM_DUMP_CSUM_EN
  ,
  output logic [DATA_W-1:0] csum
`endif
);

  typedef enum logic [2:0] {IDLE, HOLD, READ, DRAIN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg;
  logic [CNT_W-1:0]  issue_cnt_reg;
  logic [CNT_W-1:0]  rem_cnt_reg;
  logic              inflight_reg;
  logic [ADDR_W-1:0] inflight_addr_reg;
  logic [DATA_W-1:0] fifo_data [2];
  logic [ADDR_W-1:0] fifo_addr [2];
  logic              fifo_last [2];
  logic              wr_ptr_reg, rd_ptr_reg;
  logic [1:0]        count_reg;
  logic              accept, push, pop, issue;
  logic [2:0]        slots_used;

  assign accept    = (state_reg == IDLE) && start;
  assign push      = inflight_reg;
  assign out_valid = (count_reg != 2'd0);
  assign pop       = out_valid && out_ready;
  // A word leaving this cycle frees its slot, which sustains one word per cycle.
  assign slots_used = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
  assign issue      = (state_reg == READ) && (issue_cnt_reg != '0) && (slots_used < 3'd2);

  assign out_data  = fifo_data[rd_ptr_reg];
  assign out_addr  = fifo_addr[rd_ptr_reg];
  assign out_last  = fifo_last[rd_ptr_reg];
  assign mem_rd_en = issue;
  assign mem_addr  = issue ? ptr_reg : '0;

  always_comb begin
    state_next = state_reg;
    cpu_hold   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = (word_cnt == '0) ? DONE : HOLD;
      end
      HOLD: begin
        cpu_hold = 1'b1;
        if (cpu_idle) state_next = READ;
      end
      READ: begin
        cpu_hold = 1'b1;
        if (issue && (issue_cnt_reg == CNT_W'(1))) state_next = DRAIN;
      end
      DRAIN: begin
        cpu_hold = 1'b1;
        if ((count_reg == 2'd0) && !inflight_reg) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_reg           <= '0;
      issue_cnt_reg     <= '0;
      rem_cnt_reg       <= '0;
      inflight_reg      <= 1'b0;
      inflight_addr_reg <= '0;
      wr_ptr_reg        <= 1'b0;
      rd_ptr_reg        <= 1'b0;
      count_reg         <= 2'd0;
    end else begin
      if (accept) begin
        ptr_reg       <= base_addr;
        issue_cnt_reg <= word_cnt;
      end else if (issue) begin
        ptr_reg       <= ptr_reg + ADDR_W'(1);
        issue_cnt_reg <= issue_cnt_reg - CNT_W'(1);
      end
      // rem_cnt counts words still to enter the FIFO; it tags the final one.
      if (accept)    rem_cnt_reg <= word_cnt;
      else if (push) rem_cnt_reg <= rem_cnt_reg - CNT_W'(1);
      inflight_reg <= issue;
      if (issue) inflight_addr_reg <= ptr_reg;
      if (push)  wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)   rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        fifo_data[gi] <= '0;
        fifo_addr[gi] <= '0;
        fifo_last[gi] <= 1'b0;
      end else if (push && (wr_ptr_reg == 1'(gi))) begin
        fifo_data[gi] <= mem_rdata;
        fifo_addr[gi] <= inflight_addr_reg;
        fifo_last[gi] <= (rem_cnt_reg == CNT_W'(1));
      end
    end
  end

`ifdef MEM_DUMP_CSUM_EN
  logic [DATA_W-1:0] csum_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        csum_reg <= '0;
    else if (accept) csum_reg <= '0;
    else if (pop)    csum_reg <= csum_reg + out_data;
  end

  assign csum = csum_reg;
`endif

endmodule
